// File: rtl/gt_rx_link_monitor_pkg.sv
// Shared definitions for the GT RX link monitor.
// Holds the FSM state encoding, the rxbufstatus codes, the default IDLE
// K-word and the word classifier used by the monitor top.
package gt_link_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned K_W     = 2;
    localparam int unsigned BUFST_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_BLIND = 3'd2,
        ST_LOCK  = 3'd3,
        ST_UP    = 3'd4
    } link_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_BAD  = 2'd2
    } word_class_t;

    // rxbufstatus codes reported by the elastic buffer
    localparam logic [BUFST_W-1:0] BUF_NOMINAL   = 3'b000;
    localparam logic [BUFST_W-1:0] BUF_BELOW_MIN = 3'b001;
    localparam logic [BUFST_W-1:0] BUF_ABOVE_MAX = 3'b010;
    localparam logic [BUFST_W-1:0] BUF_UNDERFLOW = 3'b101;
    localparam logic [BUFST_W-1:0] BUF_OVERFLOW  = 3'b110;

    // IDLE word carries the comma in the upper byte
    localparam logic [DATA_W-1:0] IDLE_WORD = 16'hbc95;
    localparam logic [K_W-1:0]    IDLE_K    = 2'b10;

    // A K-flag anywhere other than the exact IDLE pattern is a framing fault
    function automatic word_class_t classify(
        input logic [DATA_W-1:0] data,
        input logic [K_W-1:0]    k,
        input logic [DATA_W-1:0] idle_word,
        input logic [K_W-1:0]    idle_k
    );
        if (k == idle_k && data == idle_word) begin
            return W_IDLE;
        end else if (k == '0) begin
            return W_DATA;
        end else begin
            return W_BAD;
        end
    endfunction

endpackage

// File: rtl/gt_rx_link_monitor_if.sv
// GT RX-side bundle between the elastic buffer and the link monitor.
//   rx_data_i/rx_k_i/rx_aligned_i/rx_bufstatus_i : GT receive side
//   rx_realign_o                                 : realign request to GT
//   rx_data_o/rx_valid_o                         : forwarded payload
// master drives the GT side (transceiver/bench), slave is the monitor.
interface gt_rx_link_monitor_if
    import gt_link_pkg::*;
    ();

    logic [DATA_W-1:0]  rx_data_i;
    logic [K_W-1:0]     rx_k_i;
    logic               rx_aligned_i;
    logic [BUFST_W-1:0] rx_bufstatus_i;
    logic               rx_realign_o;
    logic [DATA_W-1:0]  rx_data_o;
    logic               rx_valid_o;

    modport master (
        output rx_data_i, rx_k_i, rx_aligned_i, rx_bufstatus_i,
        input  rx_realign_o, rx_data_o, rx_valid_o
    );

    modport slave (
        input  rx_data_i, rx_k_i, rx_aligned_i, rx_bufstatus_i,
        output rx_realign_o, rx_data_o, rx_valid_o
    );

endinterface

// File: rtl/gt_rx_link_monitor_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset
//   clr_i   : clear, wins over a same-cycle increment
//   inc_i   : count one event
//   cnt_o   : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned g_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [g_WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && cnt_o != '1) begin
            cnt_o <= cnt_o + g_WIDTH'(1);
        end
    end

endmodule

// File: rtl/gt_rx_link_monitor.sv
// RX link monitor downstream of the GTPE2 elastic buffer.
// Waits for comma alignment, sits out a blind period, then needs a run of
// correctly placed IDLE K-words before declaring the link up and forwarding
// DATA words with a valid strobe. Any framing or buffer fault sends it back
// to realignment; fault events feed saturating counters.
//   usrclk_i, rst_n_i       : GT user clock, synchronous active-low reset
//   en_i                    : monitor enable
//   cnt_clr_i               : clears all error counters
//   rx                      : GT receive bundle (slave modport)
//   link_up_o               : link qualified
//   err_*_cnt_o             : comma / overflow / underflow / clock-correction
module gt_rx_link_monitor
    import gt_link_pkg::*;
#(
    parameter logic [DATA_W-1:0] g_IDLE         = IDLE_WORD,
    parameter logic [K_W-1:0]    g_IDLE_K       = IDLE_K,
    parameter int unsigned       g_BLIND_PERIOD = 10,
    parameter int unsigned       g_LOCK_IDLES   = 4,
    parameter int unsigned       g_IDLE_PERIOD  = 193,
    parameter int unsigned       g_CNT_WIDTH    = 16
) (
    input  logic                   usrclk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   cnt_clr_i,
    gt_rx_link_monitor_if.slave    rx,
    output logic                   link_up_o,
    output logic [g_CNT_WIDTH-1:0] err_comma_cnt_o,
    output logic [g_CNT_WIDTH-1:0] err_ovf_cnt_o,
    output logic [g_CNT_WIDTH-1:0] err_unf_cnt_o,
    output logic [g_CNT_WIDTH-1:0] err_clkcor_cnt_o
);

    localparam int unsigned BLIND_W = $clog2(g_BLIND_PERIOD + 1);
    localparam int unsigned LOCK_W  = $clog2(g_LOCK_IDLES + 1);
    localparam int unsigned WD_W    = $clog2(g_IDLE_PERIOD + 1);

    link_state_t        state;
    link_state_t        nxt_c;
    logic [BLIND_W-1:0] blind_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [WD_W-1:0]    wd_cnt;

    word_class_t        wclass_c;
    logic               in_mon_c;
    logic               warn_c;
    logic               comma_ev_c;
    logic               ovf_ev_c;
    logic               unf_ev_c;
    logic               clkcor_ev_c;
    logic               fwd_c;

    // Event decode and next state; priority is enable, alignment, buffer, framing
    always_comb begin
        wclass_c    = classify(rx.rx_data_i, rx.rx_k_i, g_IDLE, g_IDLE_K);
        in_mon_c    = (state == ST_LOCK) || (state == ST_UP);
        warn_c      = (rx.rx_bufstatus_i == BUF_BELOW_MIN) ||
                      (rx.rx_bufstatus_i == BUF_ABOVE_MAX);
        comma_ev_c  = in_mon_c && (wclass_c == W_BAD);
        ovf_ev_c    = in_mon_c && (rx.rx_bufstatus_i == BUF_OVERFLOW);
        unf_ev_c    = in_mon_c && (rx.rx_bufstatus_i == BUF_UNDERFLOW);
        // Fires on the g_IDLE_PERIOD-th consecutive warning cycle
        clkcor_ev_c = in_mon_c && warn_c && (wd_cnt == WD_W'(g_IDLE_PERIOD - 1));

        nxt_c = state;
        if (state == ST_IDLE) begin
            if (en_i) begin
                nxt_c = ST_ALIGN;
            end
        end else if (!en_i) begin
            nxt_c = ST_IDLE;
        end else if (!rx.rx_aligned_i) begin
            nxt_c = ST_ALIGN;
        end else begin
            case (state)
                ST_ALIGN: nxt_c = ST_BLIND;
                ST_BLIND: begin
                    if (blind_cnt == BLIND_W'(g_BLIND_PERIOD)) begin
                        nxt_c = ST_LOCK;
                    end
                end
                ST_LOCK, ST_UP: begin
                    if (ovf_ev_c || unf_ev_c || comma_ev_c) begin
                        nxt_c = ST_ALIGN;
                    end else if (state == ST_LOCK && wclass_c == W_IDLE &&
                                 lock_cnt == LOCK_W'(g_LOCK_IDLES - 1)) begin
                        nxt_c = ST_UP;
                    end
                end
                default: nxt_c = ST_IDLE;
            endcase
        end

        fwd_c = (state == ST_UP) && (nxt_c == ST_UP) && (wclass_c == W_DATA);
    end

    // State register, phase counters and registered outputs
    always_ff @(posedge usrclk_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            blind_cnt       <= '0;
            lock_cnt        <= '0;
            wd_cnt          <= '0;
            link_up_o       <= 1'b0;
            rx.rx_realign_o <= 1'b0;
            rx.rx_valid_o   <= 1'b0;
            rx.rx_data_o    <= '0;
        end else begin
            state <= nxt_c;

            // Blind counter restarts on every entry into ST_BLIND
            if (state == ST_BLIND && nxt_c == ST_BLIND) begin
                blind_cnt <= blind_cnt + BLIND_W'(1);
            end else begin
                blind_cnt <= '0;
            end

            // DATA in ST_LOCK holds the IDLE run; any exit discards it
            if (state == ST_LOCK && nxt_c == ST_LOCK) begin
                if (wclass_c == W_IDLE) begin
                    lock_cnt <= lock_cnt + LOCK_W'(1);
                end
            end else begin
                lock_cnt <= '0;
            end

            if (in_mon_c && warn_c && !clkcor_ev_c) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end

            link_up_o       <= (nxt_c == ST_UP);
            rx.rx_realign_o <= (nxt_c == ST_ALIGN) && !rx.rx_aligned_i;
            rx.rx_valid_o   <= fwd_c;
            if (fwd_c) begin
                rx.rx_data_o <= rx.rx_data_i;
            end
        end
    end

    sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_cnt_comma (
        .clk_i   (usrclk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (comma_ev_c),
        .cnt_o   (err_comma_cnt_o)
    );

    sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_cnt_ovf (
        .clk_i   (usrclk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (ovf_ev_c),
        .cnt_o   (err_ovf_cnt_o)
    );

    sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_cnt_unf (
        .clk_i   (usrclk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (unf_ev_c),
        .cnt_o   (err_unf_cnt_o)
    );

    sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_cnt_clkcor (
        .clk_i   (usrclk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (clkcor_ev_c),
        .cnt_o   (err_clkcor_cnt_o)
    );

endmodule
